pc_sequencer: RTL

//   Holds the SPARC-style PC/nPC pair and advances it each cycle. Consumes the branch

---
 rtl/sparc_pkg.sv | 21 ++
 rtl/pc_next_sel.sv | 102 ++++++++++
 rtl/pc_sequencer.sv | 77 +++++++
 3 files changed

// File: rtl/sparc_pkg.sv
// Shared types and constants for the SPARC-style PC sequencer.
// Provides the sequencer state encoding, the word/instruction sizes, and a
// helper that flags an instruction address whose low two bits are not zero.
package sparc_pkg;

  localparam int WORD_W     = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_SQUASH = 2'd2,
    S_TRAP   = 2'd3
  } state_t;

  // Only the low two bits decide alignment of an instruction address.
  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return addr_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-state selection for the PC/nPC pair.
// Ports: current pc/npc/state/misalign in, branch and trap requests in,
//        next pc/npc/state/inst_valid/misalign out. No storage here.
// Optional trap support is compiled in with PC_SEQ_TRAP_EN.
module pc_next_sel
  import sparc_pkg::*;
#(
  parameter logic [WORD_W-1:0] PC_INC   = 32'(INST_BYTES),
  parameter logic [WORD_W-1:0] TBR_BASE = 32'h0000_1000
) (
  input  state_t            state_q,
  input  logic [WORD_W-1:0] pc_q,
  input  logic [WORD_W-1:0] npc_q,
  input  logic              misalign_q,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic              br_always,
  input  logic              br_annul,
  input  logic [WORD_W-1:0] br_target,
  input  logic              trap_req,
  input  logic [7:0]        trap_type,
  output state_t            state_d,
  output logic [WORD_W-1:0] pc_d,
  output logic [WORD_W-1:0] npc_d,
  output logic              inst_valid_d,
  output logic              misalign_d
);

  logic              trap_take;
  logic [WORD_W-1:0] trap_vec;
  logic [WORD_W-1:0] seq_npc;
  logic              redirect;
  logic              annul_slot;

`ifdef PC_SEQ_TRAP_EN
  assign trap_take = trap_req;
  assign trap_vec  = TBR_BASE | {20'b0, trap_type, 4'b0000};
`else
  logic unused_trap;
  assign trap_take   = 1'b0;
  assign trap_vec    = '0;
  assign unused_trap = ^{trap_req, trap_type, TBR_BASE};
`endif

  assign seq_npc  = npc_q + PC_INC;  // wraps modulo 2^32 by width
  assign redirect = br_valid & br_taken;
  // SPARC annul: untaken conditional or any unconditional CTI with a=1
  // kills the delay slot; a taken conditional with a=1 still executes it.
  assign annul_slot = br_valid & br_annul & (~br_taken | br_always);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    npc_d        = npc_q;
    inst_valid_d = 1'b0;
    misalign_d   = misalign_q;
    if (trap_take) begin
      // Flush: discard any pending CTI, vector to the trap table.
      state_d    = S_TRAP;
      pc_d       = trap_vec;
      npc_d      = trap_vec + PC_INC;
      misalign_d = 1'b0;
    end else begin
      case (state_q)
        // Boot and trap entry hold pc so the first instruction issues next.
        S_BOOT, S_TRAP: begin
          state_d      = S_RUN;
          inst_valid_d = 1'b1;
        end
        S_RUN: begin
          pc_d = npc_q;
          if (redirect) begin
            npc_d      = br_target;
            misalign_d = is_misaligned(br_target[1:0]);
          end else begin
            npc_d      = seq_npc;
            misalign_d = 1'b0;
          end
          if (annul_slot) begin
            state_d      = S_SQUASH;
            inst_valid_d = 1'b0;
          end else begin
            state_d      = S_RUN;
            inst_valid_d = 1'b1;
          end
        end
        S_SQUASH: begin
          // The slot instruction is dead, so its CTI inputs are ignored.
          state_d      = S_RUN;
          pc_d         = npc_q;
          npc_d        = seq_npc;
          misalign_d   = 1'b0;
          inst_valid_d = 1'b1;
        end
        default: begin
          state_d = S_BOOT;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: SPARC-style PC/nPC holder with delay-slot and annul handling.
// Ports: clk/reset (async active-high), stall, br_* from the branch unit,
//        trap_req/trap_type (used only with PC_SEQ_TRAP_EN), pc/npc/inst_valid/misalign out.
// Branch resolved in cycle N reaches pc in N+2; stall freezes every register.
module pc_sequencer
  import sparc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD_W-1:0] PC_INC   = 32'(INST_BYTES),
  parameter logic [WORD_W-1:0] TBR_BASE = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic              br_always,
  input  logic              br_annul,
  input  logic [WORD_W-1:0] br_target,
  input  logic              trap_req,
  input  logic [7:0]        trap_type,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] npc,
  output logic              inst_valid,
  output logic              misalign
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] npc_q, npc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              misalign_q, misalign_d;

  pc_next_sel #(
    .PC_INC   (PC_INC),
    .TBR_BASE (TBR_BASE)
  ) u_next_sel (
    .state_q      (state_q),
    .pc_q         (pc_q),
    .npc_q        (npc_q),
    .misalign_q   (misalign_q),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .br_always    (br_always),
    .br_annul     (br_annul),
    .br_target    (br_target),
    .trap_req     (trap_req),
    .trap_type    (trap_type),
    .state_d      (state_d),
    .pc_d         (pc_d),
    .npc_d        (npc_d),
    .inst_valid_d (inst_valid_d),
    .misalign_d   (misalign_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      npc_q        <= RESET_PC + PC_INC;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else if (!stall) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      npc_q        <= npc_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  assign pc         = pc_q;
  assign npc        = npc_q;
  assign inst_valid = inst_valid_q;
  assign misalign   = misalign_q;

endmodule
